mxint8_dot_product_chk: RTL
===========================

// Module: mxint8_dot_product_chk
// PURPOSE
//  Synthesizable result checker on the consuming end of the MXINT8 dot-product test stream.
//  - Accepts expected float32 result and flags (result, unused, overflow, NaN) over a valid/ready port.
//  - Queues them in order and compares each against the next DUT output.
//  - Keeps pass/fail counts, captures the first failure, and reports done once the stream drains.
//  - Sits beside the MXINT8 dot-product unit: stimulus feeds the DUT inputs, this block consumes its outputs.
// PARAMETERS
//  DEPTH    8   expected-entry FIFO depth (power of 2, >=2); covers max DUT latency
//  CNT_W    16  width of pass/fail counters and case index
//  ULP_TOL  0   allowed |dut-exp| in ULPs for finite, same-sign results
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      reset: one clock; reset is asynchronous and active-low
//  exp_valid       in   1      expected entry present
//  exp_ready       out  1      checker can accept expected entry
//  exp_last        in   1      entry is last of the test stream
//  exp_result      in   32     expected float32 dot product
//  exp_unused      in   1      expected unused flag
//  exp_overflow    in   1      expected overflow flag
//  exp_nan         in   1      expected NaN flag
//  dut_valid       in   1      DUT output valid (one result per cycle max)
//  dut_result      in   32     DUT float32 result
//  dut_unused      in   1      DUT unused flag
//  dut_overflow    in   1      DUT overflow flag
//  dut_nan         in   1      DUT NaN flag
//  pass_cnt        out  CNT_W  matching results, saturating
//  fail_cnt        out  CNT_W  mismatching results, saturating
//  mismatch        out  1      1-cycle pulse per failed compare
//  first_fail_idx  out  CNT_W  0-based case index of first failure
//  first_fail_got  out  32     DUT result of first failure
//  err             out  2      sticky: [0] underflow (dut_valid with no entry), [1] drop (exp_valid while not ready)
//  done            out  1      stream complete, FIFO drained
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - FIFO empty; all counters, first_fail_*, err, mismatch and done = 0.
//  - State = IDLE; exp_ready = 1 one cycle after rst_n deasserts.
//  Push:
//  - exp_valid & exp_ready stores {last, result, flags}.
//  - exp_ready = !full & state != DONE.
//  Pop:
//  - Every dut_valid pops the oldest entry and compares it.
//  - No same-cycle bypass: an entry pushed in cycle t is poppable from t+1, so DUT latency must be >=1.
//  - dut_valid with FIFO empty (including an entry pushed the same cycle): err[0] set, no count change, no pop.
//  - Push and pop in the same cycle are allowed (occupancy unchanged). When full, exp_ready=0, so no push occurs.
//  Compare (registered): dut_valid in cycle t updates pass_cnt/fail_cnt/mismatch in cycle t+1.
//  - All three flags must be equal.
//  - If exp_nan=1: dut_result must be a NaN (exp==8'hFF, mant!=0); payload is ignored.
//  - Else if both results are zero (+0/-0): match.
//  - Else: signs must be equal and |dut_result[30:0]-exp_result[30:0]| <= ULP_TOL.
//  - First failure: latch first_fail_idx (= pass_cnt+fail_cnt before increment) and first_fail_got; hold until reset.
//  - Counters saturate at 2^CNT_W-1 and do not wrap.
//  FSM:
//  - IDLE->RUN on first push.
//  - RUN->DRAIN on push with exp_last=1.
//  - DRAIN->DONE when the FIFO is empty and no compare is pending; done=1 the same cycle.
//  - DONE is held until reset. In DONE, exp_valid is dropped (err[1]) and dut_valid sets err[0].
//  - A push with exp_last=1 from IDLE goes directly to DRAIN.
//  Reset mid-operation: FIFO contents, counts and pending compares are discarded immediately.
// TESTING
//  1. Push 3 entries (0x3F800000, flags 000); DUT returns the same values 2 cycles later -> pass_cnt=3, fail_cnt=0, mismatch never high, done=1 after last.
//  2. exp 0x40000000, dut 0x40000001, ULP_TOL=0 -> fail_cnt=1, mismatch pulse, first_fail_idx=0, first_fail_got=0x40000001. Rerun with ULP_TOL=1 -> pass.
//  3. exp_nan=1, exp 0x7FC00000, dut 0x7F800001 with dut_nan=1 -> pass. Same with dut 0x7F800000 (inf) -> fail.
//  4. exp 0x00000000, dut 0x80000000 -> pass. exp_overflow=1 but dut_overflow=0 with equal results -> fail.
//  5. Hold dut_valid=0 and push DEPTH=8 entries -> exp_ready=0; a 9th exp_valid -> err[1]=1. Push and pop together at full -> occupancy holds.
//  6. dut_valid with the FIFO empty -> err[0]=1 and counts unchanged. Assert rst_n=0 mid-stream -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/mxint8_dot_product_chk.sv
// mxint8_dot_product_chk
//   Result checker on the consuming end of the MXINT8 dot-product test stream.
//   Expected float32 results and flags arrive over a valid/ready port and are
//   queued in order. Each DUT output pops the oldest expected entry and is
//   compared against it. The block keeps saturating pass/fail counts, captures
//   the first failure, and raises done once the stream has drained.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   exp_valid/exp_ready  expected-entry handshake
//   exp_last             entry closes the test stream
//   exp_result, exp_*    expected float32 result and unused/overflow/NaN flags
//   dut_valid, dut_*     DUT result and flags (at most one per cycle)
//   pass_cnt, fail_cnt   saturating match / mismatch counts
//   mismatch             one-cycle pulse per failed compare
//   first_fail_idx/got   case index and DUT result of the first failure
//   err                  sticky: [0] DUT output with no entry, [1] dropped entry
//   done                 stream complete and FIFO drained
module mxint8_dot_product_chk #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int ULP_TOL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic             exp_last,
  input  logic [31:0]      exp_result,
  input  logic             exp_unused,
  input  logic             exp_overflow,
  input  logic             exp_nan,
  input  logic             dut_valid,
  input  logic [31:0]      dut_result,
  input  logic             dut_unused,
  input  logic             dut_overflow,
  input  logic             dut_nan,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             mismatch,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [31:0]      first_fail_got,
  output logic [1:0]       err,
  output logic             done
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          EW        = 35;  // {result[31:0], unused, overflow, nan}
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [31:0] ULP_TOL_W = 32'(ULP_TOL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // float32 NaN: all-ones exponent with a non-zero mantissa
  function automatic logic is_nan_f32(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Full entry compare; flags first, then NaN class, signed zero, ULP distance
  function automatic logic entry_match(input logic [EW-1:0] e, input logic [31:0] d,
                                       input logic [2:0] d_flags);
    logic [31:0] er;
    logic [30:0] diff;
    logic        ok;
    er = e[EW-1:3];
    if (er[30:0] >= d[30:0]) begin
      diff = er[30:0] - d[30:0];
    end else begin
      diff = d[30:0] - er[30:0];
    end
    if (e[2:0] != d_flags) begin
      ok = 1'b0;
    end else if (e[0]) begin
      ok = is_nan_f32(d);
    end else if ((er[30:0] == 31'd0) && (d[30:0] == 31'd0)) begin
      ok = 1'b1;
    end else begin
      ok = (er[31] == d[31]) && ({1'b0, diff} <= ULP_TOL_W);
    end
    return ok;
  endfunction

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  state_e           state_q, state_d;
  logic             exp_ready_q, exp_ready_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [31:0]      ff_got_q, ff_got_d;
  logic [1:0]       err_q, err_d;
  logic             done_q, done_d;

  logic             push_s;
  logic             pop_s;
  logic             match_s;

  // Push uses the registered ready; pop only sees entries stored in earlier cycles
  assign push_s  = exp_valid & exp_ready_q;
  assign pop_s   = dut_valid & (count_q != '0);
  assign match_s = entry_match(mem_q[rd_ptr_q], dut_result, {dut_unused, dut_overflow, dut_nan});

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {exp_result, exp_unused, exp_overflow, exp_nan};
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Stream FSM next state; done and ready are derived from the next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (push_s) begin
          state_d = exp_last ? ST_DRAIN : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (push_s && exp_last) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      // Compare results land on the same edge as the final pop, so an
      // empty next occupancy means nothing is left outstanding.
      ST_DRAIN: begin
        if (count_d == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    done_d      = (state_d == ST_DONE);
    exp_ready_d = (count_d != FULL_CNT) && (state_d != ST_DONE);
  end

  // Scoreboard update: counters, mismatch pulse, first-failure capture, errors
  always_comb begin
    pass_d     = pass_q;
    fail_d     = fail_q;
    mismatch_d = 1'b0;
    ff_idx_d   = ff_idx_q;
    ff_got_d   = ff_got_q;
    err_d      = err_q | {exp_valid & ~exp_ready_q, dut_valid & (count_q == '0)};
    if (pop_s && match_s) begin
      if (pass_q != '1) begin
        pass_d = pass_q + CNT_W'(1);
      end else begin
        pass_d = pass_q;
      end
    end else if (pop_s) begin
      mismatch_d = 1'b1;
      if (fail_q != '1) begin
        fail_d = fail_q + CNT_W'(1);
      end else begin
        fail_d = fail_q;
      end
      // fail_cnt saturates and never returns to zero, so zero marks "no failure yet"
      if (fail_q == '0) begin
        ff_idx_d = pass_q + fail_q;
        ff_got_d = dut_result;
      end else begin
        ff_idx_d = ff_idx_q;
        ff_got_d = ff_got_q;
      end
    end else begin
      mismatch_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      exp_ready_q <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      mismatch_q  <= 1'b0;
      ff_idx_q    <= '0;
      ff_got_q    <= 32'd0;
      err_q       <= 2'b00;
      done_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      exp_ready_q <= exp_ready_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      mismatch_q  <= mismatch_d;
      ff_idx_q    <= ff_idx_d;
      ff_got_q    <= ff_got_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign exp_ready      = exp_ready_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign mismatch       = mismatch_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_got = ff_got_q;
  assign err            = err_q;
  assign done           = done_q;

endmodule
